// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   8086-mode interrupt acknowledge sequencer for an 8259A-compatible PIC.
//   Resolves fully nested fixed priority (IR0 highest) against the ISR,
//   raises INT, runs the two-pulse INTA handshake and maintains the ISR.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   irr[7:0]     interrupt request register contents
//   imr[7:0]     interrupt mask register (1 = masked)
//   inta         one-cycle strobe per INTA bus pulse (already synchronized)
//   eoi          non-specific EOI strobe
//   seoi         specific EOI strobe
//   eoi_level    IR level cleared by seoi
//   aeoi         automatic-EOI mode enable
//   vector_base  T7..T3 of the vector byte
//   int_req      registered INT to the CPU
//   irr_clr      one-cycle one-hot clear of the acknowledged IRR bit
//   isr[7:0]     in-service register
//   vector       vector byte {vector_base, id}, held between strobes
//   vector_valid one-cycle strobe marking vector valid
module interrupt_sequencer #(
  parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  output logic       int_req,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [7:0] vector,
  output logic       vector_valid
);

  typedef enum logic {IDLE, ACK2} state_t;

  // Index of the lowest set bit (highest priority); 8 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  state_t     state;
  logic [2:0] id;
  logic       spurious;

  logic [7:0] pend;
  logic [3:0] p_hi;
  logic [3:0] s_hi;
  logic       qualifies;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] isr_nxt;

  always_comb begin
    pend      = irr & ~imr;
    p_hi      = lowest_set(pend);
    s_hi      = lowest_set(isr);
    // p_hi is 8 when pend is empty, so the compare alone covers pend != 0.
    qualifies = (p_hi < s_hi);

    set_mask = 8'h00;
    if (state == IDLE && inta && qualifies) set_mask = 8'b1 << p_hi[2:0];

    // All clears are computed from the pre-update isr; a set on the same
    // edge overrides any clear of the same bit.
    clr_mask = 8'h00;
    if (eoi && !s_hi[3]) clr_mask = clr_mask | (8'b1 << s_hi[2:0]);
    if (seoi)            clr_mask = clr_mask | (8'b1 << eoi_level);
    if (state == ACK2 && inta && aeoi && !spurious)
      clr_mask = clr_mask | (8'b1 << id);

    isr_nxt = (isr & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      int_req      <= 1'b0;
      irr_clr      <= 8'h00;
      isr          <= 8'h00;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      id           <= 3'd0;
      spurious     <= 1'b0;
    end else begin
      irr_clr      <= 8'h00;
      vector_valid <= 1'b0;
      isr          <= isr_nxt;
      case (state)
        IDLE: begin
          if (inta) begin
            if (qualifies) begin
              id       <= p_hi[2:0];
              spurious <= 1'b0;
              irr_clr  <= set_mask;
            end else begin
              id       <= SPURIOUS_ID;
              spurious <= 1'b1;
            end
            int_req <= 1'b0;
            state   <= ACK2;
          end else begin
            int_req <= qualifies;
          end
        end
        ACK2: begin
          // INT stays low and irr/imr are ignored until the second pulse.
          int_req <= 1'b0;
          if (inta) begin
            vector       <= {vector_base, id};
            vector_valid <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irr = 8'h00;
  logic [7:0] imr = 8'h00;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       seoi = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       aeoi = 1'b0;
  logic [4:0] vector_base = 5'b01000;
  logic       int_req;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic [7:0] vector;
  logic       vector_valid;

  int n_vec = 0;
  int n_fail = 0;

  interrupt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta(inta),
    .eoi(eoi), .seoi(seoi), .eoi_level(eoi_level), .aeoi(aeoi),
    .vector_base(vector_base), .int_req(int_req), .irr_clr(irr_clr),
    .isr(isr), .vector(vector), .vector_valid(vector_valid)
  );

  always #5 clk = ~clk;

  // Reference model: tracks how many INTA pulses of the current sequence
  // have been seen and the in-service set, and derives outputs from the
  // nested-priority rules directly.
  int         m_pulses = 0;      // 0: waiting for first INTA, 1: waiting for second
  logic [7:0] m_isr = 8'h00;
  int         m_id = 0;
  bit         m_spur = 1'b0;
  logic       e_int_req = 1'b0;
  logic [7:0] e_irr_clr = 8'h00;
  logic [7:0] e_vector = 8'h00;
  logic       e_vv = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int ph, sh, set_bit;
    logic [7:0] pend, old_isr;
    bit qual;
    if (!rst_n) begin
      m_pulses = 0; m_isr = 8'h00; m_id = 0; m_spur = 1'b0;
      e_int_req = 1'b0; e_irr_clr = 8'h00; e_vector = 8'h00; e_vv = 1'b0;
    end else begin
      pend = irr & ~imr;
      old_isr = m_isr;
      ph = 8; sh = 8;
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) ph = i;
        if (old_isr[i]) sh = i;
      end
      qual = (ph < sh);
      set_bit = -1;
      e_irr_clr = 8'h00;
      e_vv = 1'b0;
      if (eoi && sh < 8) m_isr[sh] = 1'b0;
      if (seoi) m_isr[eoi_level] = 1'b0;
      if (m_pulses == 0) begin
        if (inta) begin
          if (qual) begin
            m_id = ph; m_spur = 1'b0; set_bit = ph;
            e_irr_clr[ph] = 1'b1;
          end else begin
            m_id = 7; m_spur = 1'b1;
          end
          e_int_req = 1'b0;
          m_pulses = 1;
        end else begin
          e_int_req = qual;
        end
      end else begin
        e_int_req = 1'b0;
        if (inta) begin
          e_vector = 8'(int'(vector_base) * 8 + m_id);
          e_vv = 1'b1;
          if (aeoi && !m_spur) m_isr[m_id] = 1'b0;
          m_pulses = 0;
        end
      end
      if (set_bit >= 0) m_isr[set_bit] = 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks both the DUT and the model against a hand-computed value.
  task automatic pin(input string name, input logic [7:0] act, input logic [7:0] mdl,
                     input logic [7:0] lit);
    cmp(name, act, lit);
    cmp({"model_", name}, mdl, lit);
  endtask

  always @(negedge clk) begin
    cmp("int_req", {7'd0, int_req}, {7'd0, e_int_req});
    cmp("irr_clr", irr_clr, e_irr_clr);
    cmp("isr", isr, m_isr);
    cmp("vector", vector, e_vector);
    cmp("vector_valid", {7'd0, vector_valid}, {7'd0, e_vv});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_inta();
    inta = 1'b1; tick(); inta = 1'b0;
  endtask

  logic [7:0] irr_s;

  initial begin
    repeat (3) tick();
    pin("rst_isr", isr, m_isr, 8'h00);
    pin("rst_vector", vector, e_vector, 8'h00);
    pin("rst_int_req", {7'd0, int_req}, {7'd0, e_int_req}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Basic acknowledge
    irr = 8'h04; tick();
    pin("basic_int_req", {7'd0, int_req}, {7'd0, e_int_req}, 8'h01);
    pulse_inta(); irr = 8'h00;
    pin("basic_irr_clr", irr_clr, e_irr_clr, 8'h04);
    pin("basic_isr", isr, m_isr, 8'h04);
    pin("basic_int_drop", {7'd0, int_req}, {7'd0, e_int_req}, 8'h00);
    pulse_inta();
    pin("basic_vector", vector, e_vector, 8'h42);
    pin("basic_vv", {7'd0, vector_valid}, {7'd0, e_vv}, 8'h01);

    // Nesting
    irr = 8'h20; tick(); tick();
    pin("nest_lower_blocked", {7'd0, int_req}, {7'd0, e_int_req}, 8'h00);
    irr = 8'h22; tick();
    pin("nest_higher_int", {7'd0, int_req}, {7'd0, e_int_req}, 8'h01);
    pulse_inta(); irr = 8'h00;
    pin("nest_irr_clr", irr_clr, e_irr_clr, 8'h02);
    pulse_inta();
    pin("nest_isr", isr, m_isr, 8'h06);
    pin("nest_vector", vector, e_vector, 8'h41);

    // EOI and masking
    eoi = 1'b1; tick(); eoi = 1'b0;
    pin("eoi_isr", isr, m_isr, 8'h04);
    seoi = 1'b1; eoi_level = 3'd2; tick(); seoi = 1'b0;
    pin("seoi_isr", isr, m_isr, 8'h00);
    imr = 8'h08; irr = 8'h08; tick(); tick(); tick();
    pin("masked_int", {7'd0, int_req}, {7'd0, e_int_req}, 8'h00);
    irr = 8'h00; imr = 8'h00;

    // AEOI on IR7
    aeoi = 1'b1; irr = 8'h80; tick();
    pin("aeoi_int_req", {7'd0, int_req}, {7'd0, e_int_req}, 8'h01);
    pulse_inta(); irr = 8'h00;
    pin("aeoi_isr_set", isr, m_isr, 8'h80);
    pulse_inta();
    pin("aeoi_vector", vector, e_vector, 8'h47);
    pin("aeoi_isr_clear", isr, m_isr, 8'h00);
    aeoi = 1'b0;

    // Spurious: request withdrawn before the first INTA
    vector_base = 5'b10101;
    irr = 8'h08; tick();
    pin("spur_int_req", {7'd0, int_req}, {7'd0, e_int_req}, 8'h01);
    irr = 8'h00; pulse_inta();
    pin("spur_irr_clr", irr_clr, e_irr_clr, 8'h00);
    pin("spur_isr", isr, m_isr, 8'h00);
    pulse_inta();
    pin("spur_vector", vector, e_vector, 8'hAF);

    // Reset in ACK2
    irr = 8'h10; tick();
    pulse_inta(); irr = 8'h00;
    pin("pre_rst_isr", isr, m_isr, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    pin("midrst_isr", isr, m_isr, 8'h00);
    pin("midrst_vector", vector, e_vector, 8'h00);
    pin("midrst_irr_clr", irr_clr, e_irr_clr, 8'h00);
    tick(); rst_n = 1'b1;
    pulse_inta();
    pin("postrst_first_vv", {7'd0, vector_valid}, {7'd0, e_vv}, 8'h00);
    pulse_inta();
    pin("postrst_second_vv", {7'd0, vector_valid}, {7'd0, e_vv}, 8'h01);
    pin("postrst_vector", vector, e_vector, 8'hAF);

    // Randomized traffic with an IRR emulation cleared by irr_clr
    irr_s = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      irr_s = irr_s & ~e_irr_clr;
      if ($urandom_range(0, 3) == 0) irr_s = irr_s | 8'($urandom);
      if ($urandom_range(0, 15) == 0) irr_s = irr_s & 8'($urandom);
      irr = irr_s;
      if ($urandom_range(0, 31) == 0) imr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 63) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 63) == 0) vector_base = 5'($urandom);
      if (m_pulses != 0) inta = ($urandom_range(0, 1) == 0);
      else inta = (e_int_req && $urandom_range(0, 2) != 0) || ($urandom_range(0, 11) == 0);
      eoi = ($urandom_range(0, 7) == 0);
      seoi = ($urandom_range(0, 9) == 0);
      eoi_level = 3'($urandom);
      if (cyc % 700 == 350) begin
        #1 rst_n = 1'b0;
        tick();
        #1 rst_n = 1'b1;
      end
    end
    inta = 1'b0; eoi = 1'b0; seoi = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Controls the 8086-mode interrupt acknowledge sequence for the 8259A-compatible PIC. It takes masked interrupt requests and applies fully nested, fixed priority (IR0 highest), checked against the In-Service Register (ISR). It raises INT and runs the two-pulse INTA handshake, then sets and clears ISR bits. The block sits between the IRR/IMR registers and the data-bus buffer: it pulses IRR clears back to the IRR and returns the vector byte to the bus interface.

## Interface
- `SPURIOUS_ID`, 3'd7: IR level reported when the first INTA finds no valid request.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irr`  in  8  Interrupt Request Register contents.
- `imr`  in  8  Interrupt Mask Register; 1 = masked.
- `inta`  in  1  one-cycle strobe per INTA bus pulse, already synchronized to `clk`.
- `eoi`  in  1  one-cycle strobe, non-specific EOI command.
- `seoi`  in  1  one-cycle strobe, specific EOI command.
- `eoi_level`  in  3  IR level cleared by `seoi`.
- `aeoi`  in  1  automatic-EOI mode enable (from ICW4).
- `vector_base`  in  5  T7..T3 from ICW2.
- `int_req`  out  1  registered INT output to the CPU.
- `irr_clr`  out  8  one-cycle one-hot pulse that clears the acknowledged IRR bit.
- `isr`  out  8  In-Service Register.
- `vector`  out  8  vector byte `{vector_base, id}`.
- `vector_valid`  out  1  one-cycle strobe; `vector` is valid this cycle.

## Operation
- Pending set is `pend = irr & ~imr`. `p_hi` is the lowest set index of `pend`. `s_hi` is the lowest set index of `isr`; `s_hi` = 8 when `isr` = 0.
- Request qualifies when `pend` ≠ 0 and `p_hi < s_hi` (strictly higher priority than everything in service).
- FSM states:
  - IDLE: `int_req` <= qualifies. On `inta`:
    - If it qualifies, latch `id` = `p_hi`, set `isr[id]`, pulse `irr_clr[id]`.
    - Otherwise latch `id` = `SPURIOUS_ID`, with no ISR change and no `irr_clr`.
    - In both cases clear `int_req` and go to ACK2.
  - ACK2: `int_req` held 0; `irr`/`imr` changes are ignored. On `inta`, drive `vector` = `{vector_base, id}` with `vector_valid` = 1 for one cycle. If `aeoi` = 1 and the request was non-spurious, clear `isr[id]` in the same cycle. Go to IDLE.
- `eoi`: clears `isr[s_hi]`. No effect when `isr` = 0.
- `seoi`: clears `isr[eoi_level]`, regardless of priority.
- EOI commands are accepted in any state.
- Simultaneous events:
  - ISR set in IDLE together with an EOI targeting a different bit: both apply.
  - `seoi` targeting the bit being set in the same cycle: the set wins.
  - `eoi` in the same cycle as an ISR set: `s_hi` is computed from the pre-update `isr`.
- `vector` holds its last value between strobes.

## Timing
- Reset values: state IDLE, `int_req` = 0, `isr` = 0, `irr_clr` = 0, `vector` = 0, `vector_valid` = 0, `id` = 0.
- Reset asserted mid-sequence aborts to IDLE immediately, with no `vector_valid` issued.
- `int_req` follows a qualifying `pend` with one cycle of latency, and drops in the cycle after the first `inta`.
- `irr_clr` is high in the cycle after the first `inta` is sampled. `isr` updates on the same edge.
- `vector_valid` is high in the cycle after the second `inta` is sampled.
- With AEOI, the `isr` bit returns to 0 on that same edge.
- After returning to IDLE, `int_req` may re-assert on the following edge.
- Back-to-back `inta` strobes on consecutive cycles are legal.
- `inta` must not be held high longer than one cycle.
- EOI effects are visible in `isr` one cycle after the strobe. Any resulting `int_req` change appears one cycle after that.

## Test plan
- Basic acknowledge: `imr` = 0, `irr` = 8'b0000_0100, `vector_base` = 5'b01000.
  - `int_req` = 1 after one cycle.
  - First `inta`: `irr_clr` = 8'h04, `isr` = 8'h04, `int_req` = 0.
  - Second `inta`: `vector` = 8'h42, `vector_valid` = 1.
- Nesting: with `isr` = 8'h04, raise `irr` bit 5 → `int_req` stays 0. Raise bit 1 → `int_req` = 1. Full acknowledge gives `isr` = 8'h06.
- EOI and masking:
  - `isr` = 8'h06, `eoi` → `isr` = 8'h04.
  - `seoi` with `eoi_level` = 2 → `isr` = 8'h00.
  - A masked `irr` bit never raises `int_req`.
- AEOI: `aeoi` = 1, `irr` = 8'h80. After the second `inta`, `vector` = `{vector_base, 3'd7}` and `isr` = 8'h00.
- Spurious: `int_req` = 1 from IR3, then `irr` drops before the first `inta`. Result: no `irr_clr`, `isr` unchanged, vector id = 7.
- Reset mid-sequence: assert `rst_n` = 0 in ACK2 → all outputs 0 at once, FSM in IDLE, and no `vector_valid` on a later `inta` until a new first `inta`.
